paddle_emulator: RTL and testbench
==================================

Name: paddle_emulator

Overview:
- Parametrised successor to the two-player paddle/capacitor emulation inside the AY-3-8500 top level.
- Emulates NUM_PLAYERS Atari-style paddle RC timers. Per player, the pot value comes from digital up/down buttons (with frame-based acceleration), an 8-bit analog stick, or a direct paddle byte.
- Per player it drives the chip's LP/RP "capacitor charged" input: high once a per-frame count, loaded on vsync and decremented on each hsync, reaches zero.
- Sits between the input decoders (PS/2, joystick) and ay38500NTSC in the clk_sys domain.

Parameters:
- NUM_PLAYERS, 2, number of independent paddle channels.
- POS_MAX, 255, upper saturation limit of the button-driven position. Range 1..511.
- POS_RESET, 128, position loaded at reset. Must be ≤ POS_MAX.
- SPEED_SLOW, 5, base step per frame when speed_fast=0 (1..31).
- SPEED_FAST, 8, base step per frame when speed_fast=1 (1..31).
- ACCEL_SHIFT, 3, number of held frames per +1 acceleration increment.
- ACCEL_MAX, 8, maximum extra step added by acceleration (0 disables acceleration).

Ports:
- clk_sys, in, 1, system clock (48 MHz).
- reset_n, in, 1, asynchronous active-low reset.
- hs, in, 1, horizontal sync, active-high.
- vs, in, 1, vertical sync, active-high.
- speed_fast, in, 1, selects SPEED_FAST as the base step.
- btn_up, in, NUM_PLAYERS, per-player up button (bit i = player i).
- btn_down, in, NUM_PLAYERS, per-player down button.
- src_sel, in, 2*NUM_PLAYERS, per-player source: 0 = buttons, 1 = analog high byte, 2 = analog low byte, 3 = paddle byte.
- invert, in, NUM_PLAYERS, per-player XOR of the loaded value with 8'hFF.
- analog_in, in, 16*NUM_PLAYERS, per-player signed stick {Y[15:8], X[7:0]}.
- paddle_in, in, 8*NUM_PLAYERS, per-player unsigned paddle byte.
- pin_out, out, NUM_PLAYERS, 1 when cap_i == 0 (drives LPin/RPin).
- pos_out, out, 9*NUM_PLAYERS, current button-driven position per player.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - pos_i = POS_RESET, cap_i = 0, hold_i = 0, so pin_out = all ones.
  - Sync history registers cleared.
- Edge detect:
  - hs and vs are registered once (hs_q, vs_q).
  - vs_rise = vs & ~vs_q; hs_rise = hs & ~hs_q.
  - All state updates happen in the clock of the rise.
- On vs_rise, for each player i:
  - Load the count by source:
    - Buttons (0): cap_i ← pos_i[7:0] ^ {8{invert_i}}.
    - Analog (1): cap_i ← {~a[15], a[14:8]} ^ inv.
    - Analog (2): cap_i ← {~a[7], a[6:0]} ^ inv.
    - Paddle (3): cap_i ← paddle_i ^ inv.
  - cap_i is 9 bits; bit 8 is always loaded as 0.
  - Buttons mode only:
    - step = base + min(hold_i >> ACCEL_SHIFT, ACCEL_MAX), where base = speed_fast ? SPEED_FAST : SPEED_SLOW.
    - The step uses the hold_i value from before this frame's update.
    - Up only: pos ← (pos < step) ? 0 : pos − step.
    - Down only: pos ← (pos + step > POS_MAX) ? POS_MAX : pos + step.
    - Both or neither pressed: pos unchanged, hold_i ← 0.
    - Exactly one pressed: hold_i ← hold_i + 1, saturating at (ACCEL_MAX << ACCEL_SHIFT).
    - Arithmetic is at least 10 bits wide; no wrap-around is permitted.
  - Non-button modes: pos_i and hold_i hold their values.
- On hs_rise (and no vs_rise in the same cycle): cap_i ← cap_i − 1 if cap_i ≠ 0.
- Priority: if vs_rise and hs_rise coincide, the vs load wins and no decrement occurs.
- Latency:
  - pin_out and pos_out are registered.
  - Both change in the cycle after the edge-detect cycle; pin_out falls 1 clk after a nonzero load.
- Mid-frame changes:
  - src_sel and invert changes take effect only at the next vs_rise.
  - btn changes are sampled only at vs_rise.
- Reset asserted mid-frame: immediate return to reset values. Counting resumes at the first vs_rise after release.
- Channels are fully independent; no cross-player coupling.

Test Plan:
- Reset, then one vs_rise with buttons idle (src=0, inv=0) → cap=128, pin_out=0. Needs 128 hs_rise to go high; pin_out=1 exactly after the 128th.
- Hold up for 1 frame, speed_fast=0 → pos 128→123. Hold for 9 frames → step reaches 6 at frame 9. pos saturates at 0 and never wraps; pos_out=0.
- Hold down from pos=250, speed_fast=1 → pos=255 (POS_MAX). Up+down together → pos unchanged and hold resets, so next single-button step = base.
- src=1, analog Y=8'h80 (−128), inv=0 → cap=0, pin_out stays 1. Y=8'h7F → cap=255. With inv=1 → cap=0.
- vs and hs rising in the same clock with cap=5 → cap reloaded, not decremented. Afterwards, hs-only rise → decrement by 1.
- reset_n pulsed low mid-count with cap=77 → pin_out=1 and pos=128 asynchronously. No decrement until the next vs_rise reload.

Source files
------------

// File: rtl/paddle_emulator_if.sv
// Paddle emulator bus: sync inputs, per-player controls and pot sources,
// and the per-player pin/position outputs. master = driver, slave = emulator.
interface paddle_emulator_if #(
    parameter int NUM_PLAYERS = 2
);
    logic                       hs;
    logic                       vs;
    logic                       speed_fast;
    logic [NUM_PLAYERS-1:0]     btn_up;
    logic [NUM_PLAYERS-1:0]     btn_down;
    logic [2*NUM_PLAYERS-1:0]   src_sel;
    logic [NUM_PLAYERS-1:0]     invert;
    logic [16*NUM_PLAYERS-1:0]  analog_in;
    logic [8*NUM_PLAYERS-1:0]   paddle_in;
    logic [NUM_PLAYERS-1:0]     pin_out;
    logic [9*NUM_PLAYERS-1:0]   pos_out;

    modport master (
        output hs, vs, speed_fast, btn_up, btn_down,
        output src_sel, invert, analog_in, paddle_in,
        input  pin_out, pos_out
    );

    modport slave (
        input  hs, vs, speed_fast, btn_up, btn_down,
        input  src_sel, invert, analog_in, paddle_in,
        output pin_out, pos_out
    );
endinterface

// File: rtl/paddle_emulator.sv
// Multi-player paddle RC-timer emulation for the AY-3-8500.
// Ports: i_clk_sys, i_reset_n (async active-low), bus (slave modport).
module paddle_emulator #(
    parameter int NUM_PLAYERS = 2,
    parameter int POS_MAX     = 255,
    parameter int POS_RESET   = 128,
    parameter int SPEED_SLOW  = 5,
    parameter int SPEED_FAST  = 8,
    parameter int ACCEL_SHIFT = 3,
    parameter int ACCEL_MAX   = 8
) (
    input  logic         i_clk_sys,
    input  logic         i_reset_n,
    paddle_emulator_if.slave bus
);
    localparam int HOLD_SAT = ACCEL_MAX << ACCEL_SHIFT;
    localparam int HOLD_W   = $clog2(HOLD_SAT + 2);
    localparam logic [HOLD_W-1:0] HOLD_SAT_V = HOLD_W'(HOLD_SAT);

    logic                   r_hs_q;
    logic                   r_vs_q;
    logic                   w_hs_rise;
    logic                   w_vs_rise;

    logic [8:0]             r_cap  [NUM_PLAYERS];
    logic [8:0]             r_pos  [NUM_PLAYERS];
    logic [HOLD_W-1:0]      r_hold [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] r_pin;

    logic [8:0]             w_cap_nx  [NUM_PLAYERS];
    logic [8:0]             w_pos_nx  [NUM_PLAYERS];
    logic [HOLD_W-1:0]      w_hold_nx [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] w_pin_nx;

    assign w_vs_rise = bus.vs & ~r_vs_q;
    assign w_hs_rise = bus.hs & ~r_hs_q;

    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            logic [1:0]  v_src;
            logic [7:0]  v_inv;
            logic [15:0] v_a;
            logic [7:0]  v_load;
            logic        v_up;
            logic        v_dn;
            logic [10:0] v_base;
            logic [10:0] v_acc;
            logic [10:0] v_step;
            logic [10:0] v_pos;
            logic [10:0] v_sum;
            logic [10:0] v_diff;

            w_cap_nx[i]  = r_cap[i];
            w_pos_nx[i]  = r_pos[i];
            w_hold_nx[i] = r_hold[i];

            v_src = bus.src_sel[2*i +: 2];
            v_inv = {8{bus.invert[i]}};
            v_a   = bus.analog_in[16*i +: 16];
            v_up  = bus.btn_up[i];
            v_dn  = bus.btn_down[i];

            unique case (v_src)
                2'd0:    v_load = r_pos[i][7:0];
                2'd1:    v_load = {~v_a[15], v_a[14:8]};
                2'd2:    v_load = {~v_a[7], v_a[6:0]};
                default: v_load = bus.paddle_in[8*i +: 8];
            endcase

            // Step uses the hold count from before this frame's update.
            v_base = bus.speed_fast ? 11'(SPEED_FAST) : 11'(SPEED_SLOW);
            v_acc  = 11'(r_hold[i] >> ACCEL_SHIFT);
            if (v_acc > 11'(ACCEL_MAX))
                v_acc = 11'(ACCEL_MAX);
            v_step = v_base + v_acc;
            v_pos  = {2'b00, r_pos[i]};
            v_sum  = v_pos + v_step;
            v_diff = v_pos - v_step;

            if (w_vs_rise) begin
                w_cap_nx[i] = {1'b0, v_load ^ v_inv};
                if (v_src == 2'd0) begin
                    if (v_up ^ v_dn) begin
                        if (r_hold[i] < HOLD_SAT_V)
                            w_hold_nx[i] = r_hold[i] + 1'b1;
                        if (v_up)
                            w_pos_nx[i] = (v_pos < v_step) ?
                                          9'd0 : v_diff[8:0];
                        else
                            w_pos_nx[i] = (v_sum > 11'(POS_MAX)) ?
                                          9'(POS_MAX) : v_sum[8:0];
                    end else begin
                        w_hold_nx[i] = '0;
                    end
                end
            end else if (w_hs_rise && r_cap[i] != 9'd0) begin
                w_cap_nx[i] = r_cap[i] - 9'd1;
            end

            w_pin_nx[i] = (w_cap_nx[i] == 9'd0);
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hs_q <= 1'b0;
            r_vs_q <= 1'b0;
            r_pin  <= '1;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_cap[i]  <= '0;
                r_pos[i]  <= 9'(POS_RESET);
                r_hold[i] <= '0;
            end
        end else begin
            r_hs_q <= bus.hs;
            r_vs_q <= bus.vs;
            r_pin  <= w_pin_nx;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_cap[i]  <= w_cap_nx[i];
                r_pos[i]  <= w_pos_nx[i];
                r_hold[i] <= w_hold_nx[i];
            end
        end
    end

    assign bus.pin_out = r_pin;

    always_comb begin
        bus.pos_out = '0;
        for (int i = 0; i < NUM_PLAYERS; i++)
            bus.pos_out[9*i +: 9] = r_pos[i];
    end
endmodule

// File: tb/tb_paddle_emulator.sv
// Self-checking bench for paddle_emulator: load table plus
// button, sync-priority and reset sequences.
module tb_paddle_emulator;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    paddle_emulator_if #(.NUM_PLAYERS(2)) bus ();

    paddle_emulator #(.NUM_PLAYERS(2)) dut (
        .i_clk_sys (clk),
        .i_reset_n (reset_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          pl;
        logic [1:0]  src;
        logic        inv;
        logic [15:0] ana;
        logic [7:0]  pad;
        int          exp;
    } vec_t;

    vec_t tv [9];

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic vs_pulse();
        @(negedge clk) bus.vs = 1'b1;
        @(negedge clk) bus.vs = 1'b0;
    endtask

    task automatic hs_n(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk) bus.hs = 1'b1;
            @(negedge clk) bus.hs = 1'b0;
        end
    endtask

    function automatic int pos_of(input int pl);
        logic [17:0] p;
        p = bus.pos_out;
        return (pl == 0) ? int'(p[8:0]) : int'(p[17:9]);
    endfunction

    task automatic count_check(input string nm, input int pl, input int exp);
        check({nm, "_load"}, int'(bus.pin_out[pl]), (exp == 0) ? 1 : 0);
        if (exp > 0) begin
            hs_n(exp - 1);
            check({nm, "_pre"}, int'(bus.pin_out[pl]), 0);
            hs_n(1);
            check({nm, "_end"}, int'(bus.pin_out[pl]), 1);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        bus.hs     = 1'b0;
        bus.vs     = 1'b0;
        bus.speed_fast = 1'b0;
        bus.btn_up    = '0;
        bus.btn_down  = '0;
        bus.src_sel   = '0;
        bus.invert    = '0;
        bus.analog_in = '0;
        bus.paddle_in = '0;

        tv[0] = '{0, 2'd0, 1'b0, 16'h0000, 8'h00, 128};
        tv[1] = '{0, 2'd0, 1'b1, 16'h0000, 8'h00, 127};
        tv[2] = '{1, 2'd1, 1'b0, 16'h8000, 8'h00, 0};
        tv[3] = '{1, 2'd1, 1'b0, 16'h7F00, 8'h00, 255};
        tv[4] = '{1, 2'd1, 1'b1, 16'h7F00, 8'h00, 0};
        tv[5] = '{0, 2'd2, 1'b0, 16'h0005, 8'h00, 133};
        tv[6] = '{0, 2'd3, 1'b0, 16'h0000, 8'h2A, 42};
        tv[7] = '{1, 2'd3, 1'b0, 16'h0000, 8'h01, 1};
        tv[8] = '{1, 2'd2, 1'b0, 16'h00FF, 8'h00, 127};

        repeat (3) @(negedge clk);
        check("rst_pin", int'(bus.pin_out), 3);
        check("rst_pos0", pos_of(0), 128);
        check("rst_pos1", pos_of(1), 128);
        @(negedge clk) reset_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            bus.src_sel   = 4'b1111;
            bus.invert    = '0;
            bus.analog_in = '0;
            bus.paddle_in = '0;
            bus.src_sel[2*tv[v].pl +: 2]    = tv[v].src;
            bus.invert[tv[v].pl]            = tv[v].inv;
            bus.analog_in[16*tv[v].pl +: 16] = tv[v].ana;
            bus.paddle_in[8*tv[v].pl +: 8]  = tv[v].pad;
            vs_pulse();
            count_check($sformatf("vec%0d", v), tv[v].pl, tv[v].exp);
        end

        bus.src_sel   = '0;
        bus.invert    = '0;
        bus.btn_up[0] = 1'b1;
        vs_pulse();
        check("up_f1", pos_of(0), 123);
        for (int f = 2; f <= 8; f++) vs_pulse();
        check("up_f8", pos_of(0), 88);
        vs_pulse();
        check("up_f9", pos_of(0), 82);
        for (int f = 0; f < 30; f++) vs_pulse();
        check("up_sat0", pos_of(0), 0);
        bus.btn_up[0] = 1'b0;
        vs_pulse();

        bus.speed_fast  = 1'b1;
        bus.btn_down[0] = 1'b1;
        for (int f = 1; f <= 27; f++) vs_pulse();
        check("dn_f27", pos_of(0), 249);
        vs_pulse();
        check("dn_sat", pos_of(0), 255);
        vs_pulse();
        check("dn_hold", pos_of(0), 255);
        bus.btn_up[0] = 1'b1;
        vs_pulse();
        check("both", pos_of(0), 255);
        bus.btn_down[0] = 1'b0;
        bus.speed_fast  = 1'b0;
        vs_pulse();
        check("after_both", pos_of(0), 250);
        bus.btn_up[0] = 1'b0;
        check("p1_indep", pos_of(1), 128);

        bus.src_sel   = 4'b0011;
        bus.paddle_in = 16'h0005;
        vs_pulse();
        hs_n(2);
        @(negedge clk) begin
            bus.vs = 1'b1;
            bus.hs = 1'b1;
        end
        @(negedge clk) begin
            bus.vs = 1'b0;
            bus.hs = 1'b0;
        end
        hs_n(4);
        check("coin_pre", int'(bus.pin_out[0]), 0);
        hs_n(1);
        check("coin_end", int'(bus.pin_out[0]), 1);
        hs_n(1);
        check("zero_hold", int'(bus.pin_out[0]), 1);

        bus.paddle_in = 16'h004D;
        vs_pulse();
        hs_n(10);
        check("rst_mid_pre", int'(bus.pin_out[0]), 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_pin", int'(bus.pin_out), 3);
        check("rst_mid_pos", pos_of(0), 128);
        @(negedge clk) reset_n = 1'b1;
        hs_n(3);
        check("rst_no_dec", int'(bus.pin_out[0]), 1);
        vs_pulse();
        count_check("rst_reload", 0, 77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
